// File: rtl/uart_byte_receiver_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings and the
// bit-timing derivation that the transmitter also reuses.
package uart_byte_receiver_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clock cycles per UART bit, truncating integer division.
  function automatic int calc_bit_period(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Offset from the detected falling edge to the middle of the start bit.
  function automatic int calc_half_period(input int bit_period);
    return bit_period / 2;
  endfunction

endpackage

// File: rtl/uart_rx_synchronizer.sv
// Multi-flop synchroniser for asynchronous inputs. Flops reset to 1 so an
// idle UART line (or released button) never looks active coming out of reset.
module uart_rx_synchronizer #(
  parameter int depth = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [depth-1:0] sync_q;
  logic [depth-1:0] sync_d;

  // Shift the raw input one stage further down the chain each cycle.
  always_comb begin
    sync_d = {sync_q[depth-2:0], d};
  end

  // Chain register, preset to the idle level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[depth-1];

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART byte receiver: synchronises rx, qualifies the start bit at mid-bit,
// samples eight data bits LSB-first, checks the stop bit, and pulses either
// byte_valid or framing_error for one cycle per frame.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to go low
// START     | counting to mid start bit; low sample confirms, high is a glitch
// DATA      | sampling 8 data bits at bit_period intervals, LSB first
// STOP      | sampling the stop bit; 1 delivers the byte, 0 is a framing error
// WAIT_HIGH | after a framing error, waiting for the line to return high
module uart_byte_receiver
  import uart_byte_receiver_pkg::*;
#(
  parameter int clock_frequency = 50_000_000,
  parameter int baud_rate       = 115_200
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int bit_period  = calc_bit_period(clock_frequency, baud_rate);
  localparam int half_period = calc_half_period(bit_period);
  // Guarded so a rejected configuration does not also produce width noise.
  localparam int CNT_W       = (bit_period < 4) ? 2 : $clog2(bit_period);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(half_period - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(bit_period - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  if (bit_period < 4) begin : g_bad_bit_period
    $error("uart_byte_receiver: bit_period must be at least 4 clock cycles");
  end

  logic rx_s;

  rx_state_e        state_q,         state_d;
  logic [CNT_W-1:0] cnt_q,           cnt_d;
  logic [2:0]       bit_idx_q,       bit_idx_d;
  logic [7:0]       shift_q,         shift_d;
  logic [7:0]       byte_data_q,     byte_data_d;
  logic             byte_valid_q,    byte_valid_d;
  logic             framing_error_q, framing_error_d;

  uart_rx_synchronizer #(
    .depth(2)
  ) u_rx_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d      (rx),
    .q      (rx_s)
  );

  // Next-state, bit timing and output pulse generation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_ONE;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    byte_data_d     = byte_data_q;
    byte_valid_d    = 1'b0;
    framing_error_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Counter is held at zero so START begins counting from 0.
        cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d   = ST_STOP;
            bit_idx_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            framing_error_d = 1'b1;
            state_d         = ST_WAIT_HIGH;
          end
        end
      end

      ST_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, datapath and registered output pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      byte_data_q     <= '0;
      byte_valid_q    <= 1'b0;
      framing_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      byte_data_q     <= byte_data_d;
      byte_valid_q    <= byte_valid_d;
      framing_error_q <= framing_error_d;
    end
  end

  assign byte_data     = byte_data_q;
  assign byte_valid    = byte_valid_q;
  assign framing_error = framing_error_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver at 16 clocks per bit.
module tb_uart_byte_receiver;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx      = 1'b1;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       framing_error;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  int         v_cyc[$];
  logic [7:0] v_dat[$];
  int         f_cyc[$];
  int         both_cnt  = 0;
  bit         busy_seen = 1'b0;

  // Frame start (rx driven low) to output pulse: 2 sync cycles + 153.
  localparam int PULSE_LAT = 155;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  uart_byte_receiver #(
    .clock_frequency(1_600_000),
    .baud_rate      (100_000)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rx           (rx),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .framing_error(framing_error),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n) begin
      if (byte_valid) begin
        v_cyc.push_back(cyc);
        v_dat.push_back(byte_data);
      end
      if (framing_error) f_cyc.push_back(cyc);
      if (byte_valid && framing_error) both_cnt++;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic to_neg(input int n);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (cyc >= n) break;
    end
  endtask

  task automatic clear_mon();
    v_cyc.delete();
    v_dat.delete();
    f_cyc.delete();
    busy_seen = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(16);
    end
    rx = stop;
    tick(16);
  endtask

  initial begin
    int s;
    int r;
    logic [7:0] pat;

    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_data: 8'h55, exp_valid: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'hA3, stop: 1'b0, exp_data: 8'h55, exp_valid: 0, exp_ferr: 1};
    vecs[2] = '{data: 8'h96, stop: 1'b1, exp_data: 8'h96, exp_valid: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h01, stop: 1'b1, exp_data: 8'h01, exp_valid: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'h80, stop: 1'b1, exp_data: 8'h80, exp_valid: 1, exp_ferr: 0};

    // Reset state
    tick(3);
    check("reset_byte_data", int'(byte_data), 0);
    check("reset_byte_valid", int'(byte_valid), 0);
    check("reset_framing_error", int'(framing_error), 0);
    check("reset_busy", int'(busy), 0);
    reset_n = 1'b1;
    tick(2);

    // Idle line
    clear_mon();
    tick(10_000);
    check("idle_busy_seen", int'(busy_seen), 0);
    check("idle_valid_pulses", v_cyc.size(), 0);
    check("idle_ferr_pulses", f_cyc.size(), 0);
    check("idle_byte_data", int'(byte_data), 0);

    // Table of single frames
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      s = cyc;
      send_frame(vecs[i].data, vecs[i].stop);
      if (!vecs[i].stop) begin
        tick(40);
        r = cyc;
        rx = 1'b1;
        to_neg(r + 2);
        check($sformatf("v%0d_busy_before_release", i), int'(busy), 1);
        to_neg(r + 3);
        check($sformatf("v%0d_busy_after_release", i), int'(busy), 0);
        tick(1);
      end
      tick(20);
      check($sformatf("v%0d_valid_count", i), v_cyc.size(), vecs[i].exp_valid);
      check($sformatf("v%0d_ferr_count", i), f_cyc.size(), vecs[i].exp_ferr);
      if (vecs[i].exp_valid > 0)
        check($sformatf("v%0d_valid_time", i), (v_cyc.size() > 0) ? v_cyc[0] - s : -1, PULSE_LAT);
      else
        check($sformatf("v%0d_ferr_time", i), (f_cyc.size() > 0) ? f_cyc[0] - s : -1, PULSE_LAT);
      check($sformatf("v%0d_byte_data", i), int'(byte_data), int'(vecs[i].exp_data));
      check($sformatf("v%0d_busy_idle", i), int'(busy), 0);
    end

    // Glitch: 4 cycles low must not start a frame
    clear_mon();
    s = cyc;
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    to_neg(s + 3);
    check("glitch_busy_rises", int'(busy), 1);
    to_neg(s + 9);
    check("glitch_busy_in_start", int'(busy), 1);
    to_neg(s + 12);
    check("glitch_busy_back_idle", int'(busy), 0);
    tick(30);
    check("glitch_valid_pulses", v_cyc.size(), 0);
    check("glitch_ferr_pulses", f_cyc.size(), 0);
    check("glitch_byte_data", int'(byte_data), 8'h80);

    // Back-to-back frames, no idle gap
    clear_mon();
    s = cyc;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(20);
    check("b2b_valid_count", v_cyc.size(), 2);
    if (v_cyc.size() == 2) begin
      check("b2b_first_time", v_cyc[0] - s, PULSE_LAT);
      check("b2b_spacing", v_cyc[1] - v_cyc[0], 160);
      check("b2b_data0", int'(v_dat[0]), 8'h00);
      check("b2b_data1", int'(v_dat[1]), 8'hFF);
    end
    check("b2b_ferr_count", f_cyc.size(), 0);
    check("b2b_byte_data", int'(byte_data), 8'hFF);

    // Reset during data bit 4
    clear_mon();
    pat = 8'h5A;
    rx = 1'b0;
    tick(16);
    for (int i = 0; i < 4; i++) begin
      rx = pat[i];
      tick(16);
    end
    rx = pat[4];
    tick(8);
    reset_n = 1'b0;
    #1;
    check("midrst_byte_data", int'(byte_data), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_valid", int'(byte_valid), 0);
    check("midrst_ferr", int'(framing_error), 0);
    rx = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(200);
    check("midrst_no_valid", v_cyc.size(), 0);
    check("midrst_no_ferr", f_cyc.size(), 0);
    s = cyc;
    send_frame(8'h3C, 1'b1);
    tick(20);
    check("post_rst_valid_count", v_cyc.size(), 1);
    check("post_rst_valid_time", (v_cyc.size() > 0) ? v_cyc[0] - s : -1, PULSE_LAT);
    check("post_rst_byte_data", int'(byte_data), 8'h3C);

    check("valid_ferr_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
